// File: rtl/ccm_coe_loader.sv
// Double-buffered 3x3 colour-correction coefficient bank; shadow copied to active on a vs rising edge.
// Optional shadow readback port is enabled by defining CCM_COE_RDBACK_EN.
module ccm_coe_loader #(
  parameter int unsigned COE_WIDTH          = 16,
  parameter int unsigned COE_FRACTION_WIDTH = 10,
  parameter int unsigned COE_COUNT          = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [3:0]                     wr_addr_i,
  input  logic [COE_WIDTH-1:0]           wr_data_i,
  input  logic                           commit_i,
  input  logic                           err_clr_i,
  input  logic                           vs_i,
  output logic [COE_WIDTH*COE_COUNT-1:0] coe_o,
  output logic                           pending_o,
  output logic                           upd_o,
  output logic [7:0]                     upd_cnt_o,
  output logic                           err_o
`ifdef CCM_COE_RDBACK_EN
  ,
  input  logic [3:0]                     rd_addr_i,
  output logic [COE_WIDTH-1:0]           rd_data_o
`endif
);

  localparam logic [COE_WIDTH-1:0] COE_ONE = COE_WIDTH'(1) << COE_FRACTION_WIDTH;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t               state, state_nxt;
  logic [COE_WIDTH-1:0] shadow [COE_COUNT];
  logic                 vs_q;
  logic                 vs_edge;
  logic                 wr_ok;
  logic                 set_err;
  logic                 apply;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A commit seen in IDLE only arms, even if a vs edge coincides with it.
  always_comb begin
    state_nxt = state;
    vs_edge   = vs_i & ~vs_q;
    wr_ok     = 1'b0;
    set_err   = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en_i) begin
          if (int'(wr_addr_i) < int'(COE_COUNT)) wr_ok = 1'b1;
          else                                   set_err = 1'b1;
        end
        if (commit_i) state_nxt = ARMED;
      end
      ARMED: begin
        if (wr_en_i) set_err = 1'b1;
        if (vs_edge) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      pending_o <= 1'b0;
      upd_o     <= 1'b0;
      upd_cnt_o <= '0;
      err_o     <= 1'b0;
      for (int unsigned k = 0; k < COE_COUNT; k++) begin
        shadow[k]                         <= (k / 3 == k % 3) ? COE_ONE : '0;
        coe_o[k*COE_WIDTH +: COE_WIDTH]   <= (k / 3 == k % 3) ? COE_ONE : '0;
      end
    end else begin
      vs_q      <= vs_i;
      pending_o <= (state_nxt == ARMED);
      upd_o     <= apply;
      if (wr_ok) shadow[wr_addr_i] <= wr_data_i;
      if (apply) begin
        upd_cnt_o <= upd_cnt_o + 8'd1;
        for (int unsigned k = 0; k < COE_COUNT; k++)
          coe_o[k*COE_WIDTH +: COE_WIDTH] <= shadow[k];
      end
      if (set_err)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

`ifdef CCM_COE_RDBACK_EN
  always_ff @(posedge clk) begin
    if (rst) rd_data_o <= '0;
    else if (int'(rd_addr_i) < int'(COE_COUNT)) rd_data_o <= shadow[rd_addr_i];
    else rd_data_o <= '0;
  end
`endif

endmodule

// File: tb/tb_ccm_coe_loader.sv
// Self-checking bench for ccm_coe_loader: directed steps plus random traffic against a frame-level model.
module tb_ccm_coe_loader;

  localparam int W = 16;
  localparam int N = 9;
  localparam logic [15:0] ONE = 16'h0400;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_en_i = 1'b0;
  logic [3:0]     wr_addr_i = '0;
  logic [W-1:0]   wr_data_i = '0;
  logic           commit_i = 1'b0;
  logic           err_clr_i = 1'b0;
  logic           vs_i = 1'b0;
  logic [W*N-1:0] coe_o;
  logic           pending_o;
  logic           upd_o;
  logic [7:0]     upd_cnt_o;
  logic           err_o;
`ifdef CCM_COE_RDBACK_EN
  logic [3:0]     rd_addr_i = '0;
  logic [W-1:0]   rd_data_o;
`endif

  ccm_coe_loader #(.COE_WIDTH(16), .COE_FRACTION_WIDTH(10), .COE_COUNT(9)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .commit_i(commit_i), .err_clr_i(err_clr_i), .vs_i(vs_i), .coe_o(coe_o),
    .pending_o(pending_o), .upd_o(upd_o), .upd_cnt_o(upd_cnt_o), .err_o(err_o)
`ifdef CCM_COE_RDBACK_EN
    , .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the two banks as plain word arrays plus frame-level flags.
  logic [15:0] m_sh [N];
  logic [15:0] m_act [N];
  bit          m_armed, m_upd, m_err, m_vs_prev;
  int          m_cnt;
  logic [15:0] m_rd;

  task automatic chk(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W*N-1:0] model_bank();
    logic [W*N-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = m_act[k];
    return v;
  endfunction

  task automatic check_all();
    chk("coe", coe_o, model_bank());
    chk("pending", {143'b0, pending_o}, {143'b0, m_armed});
    chk("upd", {143'b0, upd_o}, {143'b0, m_upd});
    chk("upd_cnt", {136'b0, upd_cnt_o}, {136'b0, 8'(m_cnt)});
    chk("err", {143'b0, err_o}, {143'b0, m_err});
`ifdef CCM_COE_RDBACK_EN
    chk("rd_data", {128'b0, rd_data_o}, {128'b0, m_rd});
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_sh[k]  = (k == 0 || k == 4 || k == 8) ? ONE : 16'h0;
      m_act[k] = m_sh[k];
    end
    m_armed = 0; m_upd = 0; m_err = 0; m_vs_prev = 0; m_cnt = 0; m_rd = '0;
  endtask

  task automatic do_reset();
    rst = 1; wr_en_i = 0; commit_i = 0; err_clr_i = 0; vs_i = 0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 0;
    check_all();
  endtask

  task automatic step(input bit we, input int unsigned a, input int unsigned d,
                      input bit cm, input bit ec, input bit v, input int unsigned ra);
    bit edge_seen, new_err;
    wr_en_i = we; wr_addr_i = a[3:0]; wr_data_i = d[15:0];
    commit_i = cm; err_clr_i = ec; vs_i = v;
`ifdef CCM_COE_RDBACK_EN
    rd_addr_i = ra[3:0];
`endif
    @(posedge clk);
    m_rd = (ra < N) ? m_sh[ra] : 16'h0;
    edge_seen = v && !m_vs_prev;
    m_vs_prev = v;
    new_err = 0;
    m_upd = 0;
    if (m_armed) begin
      if (we) new_err = 1;
      if (edge_seen) begin
        for (int k = 0; k < N; k++) m_act[k] = m_sh[k];
        m_upd = 1;
        m_cnt = (m_cnt + 1) % 256;
        m_armed = 0;
      end
    end else begin
      if (we) begin
        if (a < N) m_sh[a] = d[15:0];
        else new_err = 1;
      end
      if (cm) m_armed = 1;
    end
    if (new_err) m_err = 1;
    else if (ec) m_err = 0;
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit v);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, v, 3);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_w0", {128'b0, coe_o[0*W +: W]}, {128'b0, ONE});
    chk("reset_w1", {128'b0, coe_o[1*W +: W]}, 144'h0);

    // Write k=1, commit, then vs edge.
    step(1, 1, 16'h0200, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    idle(3, 0);
    chk("pre_apply_w1", {128'b0, coe_o[1*W +: W]}, 144'h0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("apply_w1", {128'b0, coe_o[1*W +: W]}, {128'b0, 16'h0200});
    chk("apply_upd", {143'b0, upd_o}, {143'b0, 1'b1});
    idle(2, 1);
    chk("upd_once", {143'b0, upd_o}, 144'h0);
    chk("cnt1", {136'b0, upd_cnt_o}, {136'b0, 8'd1});
    idle(1, 0);

    // Write while armed is dropped and flags an error.
    step(0, 0, 0, 1, 0, 0, 2);
    step(1, 2, 16'h7FFF, 0, 0, 0, 2);
    chk("armed_wr_err", {143'b0, err_o}, {143'b0, 1'b1});
    step(0, 0, 0, 0, 0, 1, 2);
    chk("w2_unchanged", {128'b0, coe_o[2*W +: W]}, 144'h0);
    step(0, 0, 0, 0, 1, 0, 2);
    chk("err_cleared", {143'b0, err_o}, 144'h0);

    // Commit coincident with a vs edge applies only on the next edge.
    step(1, 5, 16'h1234, 0, 0, 0, 5);
    step(0, 0, 0, 1, 0, 1, 5);
    chk("coinc_no_apply", {143'b0, upd_o}, 144'h0);
    idle(2, 1);
    idle(3, 0);
    chk("coinc_pending", {143'b0, pending_o}, {143'b0, 1'b1});
    step(0, 0, 0, 0, 0, 1, 5);
    chk("coinc_apply", {128'b0, coe_o[5*W +: W]}, {128'b0, 16'h1234});
    idle(1, 0);

    // Out-of-range address, error wins over a simultaneous clear.
    step(1, 9, 16'hBEEF, 0, 1, 0, 3);
    chk("addr9_err", {143'b0, err_o}, {143'b0, 1'b1});
    step(0, 0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 1, 0, 9);

    // Counter wrap after 256 applies from reset.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
    end
    chk("cnt_wrap", {136'b0, upd_cnt_o}, 144'h0);

    // Reset while armed discards the commit.
    step(1, 0, 16'h0111, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    do_reset();
    chk("rst_armed_pend", {143'b0, pending_o}, 144'h0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("rst_armed_id", {128'b0, coe_o[0*W +: W]}, {128'b0, ONE});

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 11), $urandom,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0 ? ~vs_i : vs_i, $urandom_range(0, 11));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
